// File: rtl/msk_pkg.sv
// Shared helpers for the masked HPC1 AND: randomness sizing and share/lane indexing.
package msk_pkg;

  // Fresh random bits needed for one refresh (and for one DOM multiplication).
  function automatic int r_count(input int d);
    return (d * (d - 1)) / 2;
  endfunction

  // Index of the random bit shared by unordered share pair (i, j), i != j.
  function automatic int pair_idx(input int i, input int j, input int d);
    int lo;
    int hi;
    if (i < j) begin
      lo = i;
      hi = j;
    end else begin
      lo = j;
      hi = i;
    end
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Bit position of share i of lane j in a d*n wide sharing bus.
  function automatic int share_bit(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/msk_and_hpc1_lane.sv
// One bit lane of the HPC1 AND: refresh of b, stage-1 registers, DOM cross terms, stage-2 registers.
module msk_and_hpc1_lane
  import msk_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   en1,
  input  logic                   en2,
  input  logic [d-1:0]           a,
  input  logic [d-1:0]           b,
  input  logic [r_count(d)-1:0]  rnd_ref,
  input  logic [r_count(d)-1:0]  rnd_mul,
  output logic [d-1:0]           out
);

  logic [d-1:0]          b_ref_s;
  logic [d-1:0]          a_r;
  logic [d-1:0]          b_r;
  logic [r_count(d)-1:0] rm_r;
  logic [d*d-1:0]        t_s;
  logic [d*d-1:0]        t_r;
  logic [d-1:0]          out_s;

  // SNI refresh of b: each pair's random bit lands on both shares of the pair
  always_comb begin
    b_ref_s = b;
    for (int i = 0; i < d; i++) begin
      for (int j = i + 1; j < d; j++) begin
        b_ref_s[i] = b_ref_s[i] ^ rnd_ref[pair_idx(i, j, d)];
        b_ref_s[j] = b_ref_s[j] ^ rnd_ref[pair_idx(i, j, d)];
      end
    end
  end

  // Stage-1 capture of operands and multiplication randomness
  always_ff @(posedge clk) begin
    if (en1) begin
      a_r  <= a;
      b_r  <= b_ref_s;
      rm_r <= rnd_mul;
    end
  end

  // DOM cross-domain terms; off-diagonal terms masked by the pair's random bit
  always_comb begin
    t_s = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i != j) begin
          t_s[i*d+j] = (a_r[i] & b_r[j]) ^ rm_r[pair_idx(i, j, d)];
        end else begin
          t_s[i*d+j] = a_r[i] & b_r[j];
        end
      end
    end
  end

  // Stage-2 capture of the terms; compression happens only after this register
  always_ff @(posedge clk) begin
    if (en2) begin
      t_r <= t_s;
    end
  end

  // Output share i compresses row i of the registered terms
  always_comb begin
    out_s = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        out_s[i] = out_s[i] ^ t_r[i*d+j];
      end
    end
  end

  assign out = out_s;

endmodule

// File: rtl/msk_and_hpc1_vec.sv
// N-lane masked AND (HPC1) with a two-stage elastic pipeline; top holds only handshake and lanes.
module msk_and_hpc1_vec
  import msk_pkg::*;
#(
  parameter int d = 2,
  parameter int N = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [d*N-1:0]            ina,
  input  logic [d*N-1:0]            inb,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*r_count(d)*N-1:0] rnd,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  output logic [d*N-1:0]            out,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int R = r_count(d);

  logic v1_r;
  logic v2_r;
  logic adv2_s;
  logic s1_free_s;
  logic acc_s;

  // Stage transfer conditions; operands and randomness are taken together
  always_comb begin
    adv2_s    = v1_r & (~v2_r | out_ready);
    s1_free_s = ~v1_r | adv2_s;
    acc_s     = in_valid & rnd_valid & s1_free_s;
  end

  // Stage occupancy flags; in-flight data is dropped on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      if (acc_s) begin
        v1_r <= 1'b1;
      end else if (adv2_s) begin
        v1_r <= 1'b0;
      end else begin
        v1_r <= v1_r;
      end
      if (adv2_s) begin
        v2_r <= 1'b1;
      end else if (v2_r & out_ready) begin
        v2_r <= 1'b0;
      end else begin
        v2_r <= v2_r;
      end
    end
  end

  assign in_ready  = rnd_valid & s1_free_s;
  assign rnd_ready = in_valid & s1_free_s;
  assign out_valid = v2_r;

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [d-1:0] a_s;
    logic [d-1:0] b_s;
    logic [d-1:0] o_s;

    for (genvar i = 0; i < d; i++) begin : g_share
      assign a_s[i] = ina[share_bit(i, j, N)];
      assign b_s[i] = inb[share_bit(i, j, N)];
      assign out[share_bit(i, j, N)] = o_s[i];
    end

    msk_and_hpc1_lane #(
      .d(d)
    ) u_lane (
      .clk     (clk),
      .en1     (acc_s),
      .en2     (adv2_s),
      .a       (a_s),
      .b       (b_s),
      .rnd_ref (rnd[j*R +: R]),
      .rnd_mul (rnd[R*N + j*R +: R]),
      .out     (o_s)
    );
  end

endmodule

// File: tb/tb_msk_and_hpc1_vec.sv
// Self-checking bench: unshared product model for a d=2,N=4 instance plus a d=3,N=8 instance.
module tb_msk_and_hpc1_vec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // d=2, N=4 instance
  logic       rst_n;
  logic [7:0] ina, inb, rnd, out;
  logic       in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;

  // d=3, N=8 instance
  logic        rst1_n;
  logic [23:0] ina1, inb1, out1;
  logic [47:0] rnd1;
  logic        in_valid1, in_ready1, rnd_valid1, rnd_ready1, out_valid1, out_ready1;

  int ntx, cur_run, max_run;

  msk_and_hpc1_vec #(.d(2), .N(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .in_valid(in_valid), .in_ready(in_ready),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  msk_and_hpc1_vec #(.d(3), .N(8)) dut1 (
    .clk(clk), .rst_n(rst1_n), .ina(ina1), .inb(inb1), .in_valid(in_valid1), .in_ready(in_ready1),
    .rnd(rnd1), .rnd_valid(rnd_valid1), .rnd_ready(rnd_ready1),
    .out(out1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  function automatic logic [3:0] comb0(input logic [7:0] v);
    return v[3:0] ^ v[7:4];
  endfunction

  function automatic logic [7:0] comb1(input logic [23:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair with randomness and wait (bounded) until it is accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    logic ok;
    logic [63:0] t;
    t = rand64();
    ina = a; inb = b; rnd = t[7:0];
    in_valid = 1'b1; rnd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 20 cycles");
    end
    in_valid = 1'b0; rnd_valid = 1'b0;
  endtask

  // Behavioural model of dut0: at most one product in each pipeline stage, compared every cycle.
  initial begin
    logic       s1_has, s2_has, hold_p;
    logic [3:0] s1_val, s2_val;
    logic [7:0] out_p;
    logic       adv_m, free_m, acc_m;
    s1_has = 1'b0; s2_has = 1'b0; hold_p = 1'b0;
    s1_val = 4'h0; s2_val = 4'h0; out_p = 8'h00;
    @(posedge clk);
    forever begin
      @(negedge clk);
      adv_m  = s1_has && (!s2_has || out_ready);
      free_m = !s1_has || adv_m;
      chk("out_valid", 64'(out_valid), 64'(s2_has));
      chk("in_ready", 64'(in_ready), 64'(rnd_valid && free_m));
      chk("rnd_ready", 64'(rnd_ready), 64'(in_valid && free_m));
      if (s2_has) chk("out_data", 64'(comb0(out)), 64'(s2_val));
      if (hold_p) chk("out_hold", 64'(out), 64'(out_p));
      if (out_valid) begin
        cur_run++;
        if (out_ready) ntx++;
      end else begin
        cur_run = 0;
      end
      if (cur_run > max_run) max_run = cur_run;
      hold_p = s2_has && !out_ready && rst_n;
      out_p  = out;
      acc_m  = in_valid && rnd_valid && free_m;
      if (!rst_n) begin
        s1_has = 1'b0; s2_has = 1'b0;
      end else begin
        if (adv_m) begin
          s2_has = 1'b1; s2_val = s1_val;
        end else if (s2_has && out_ready) begin
          s2_has = 1'b0;
        end
        if (acc_m) begin
          s1_has = 1'b1; s1_val = comb0(ina) & comb0(inb);
        end else if (adv_m) begin
          s1_has = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [63:0] t;
    logic [23:0] o_z, o_r;
    logic [7:0]  exp1;
    rst_n = 1'b0; ina = 8'h00; inb = 8'h00; rnd = 8'h00;
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    rst1_n = 1'b0; ina1 = 24'h0; inb1 = 24'h0; rnd1 = 48'h0;
    in_valid1 = 1'b0; rnd_valid1 = 1'b0; out_ready1 = 1'b1;
    ntx = 0; cur_run = 0; max_run = 0;
    repeat (3) step();
    // Reset-time handshake: readies mirror the other side's valid
    rnd_valid = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_rnd_ready", 64'(rnd_ready), 64'd0);
    step();
    rnd_valid = 1'b0; rst_n = 1'b1;
    step();

    // Single transfer: 0x5^0xA = 0xF, 0x6^0x5 = 0x3, product 0x3 after two cycles
    t = rand64();
    ina = {4'hA, 4'h5}; inb = {4'h5, 4'h6}; rnd = t[7:0];
    in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    chk("r36_acc", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; rnd_valid = 1'b0;
    @(negedge clk);
    chk("r36_lat1", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    chk("r36_lat2", 64'(out_valid), 64'd1);
    chk("r36_val", 64'(comb0(out)), 64'h3);
    repeat (3) step();

    // Eight back-to-back transfers
    ntx = 0; cur_run = 0; max_run = 0;
    for (int k = 0; k < 8; k++) begin
      t = rand64();
      send(t[7:0], t[15:8]);
    end
    repeat (5) step();
    chk("r37_count", 64'(ntx), 64'd8);
    chk("r37_run", 64'(max_run), 64'd8);

    // Stall with both stages full
    ntx = 0;
    out_ready = 1'b0;
    t = rand64();
    send(t[7:0], t[15:8]);
    send(t[23:16], t[31:24]);
    ina = t[39:32]; inb = t[47:40]; in_valid = 1'b1; rnd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("r38_in_ready", 64'(in_ready), 64'd0);
      chk("r38_rnd_ready", 64'(rnd_ready), 64'd0);
      chk("r38_out_valid", 64'(out_valid), 64'd1);
      step();
    end
    out_ready = 1'b1;
    send(t[39:32], t[47:40]);
    repeat (5) step();
    chk("r38_count", 64'(ntx), 64'd3);

    // Operands waiting on randomness
    ntx = 0;
    t = rand64();
    ina = t[7:0]; inb = t[15:8]; in_valid = 1'b1; rnd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("r39_in_ready", 64'(in_ready), 64'd0);
      chk("r39_rnd_ready", 64'(rnd_ready), 64'd1);
      chk("r39_no_out", 64'(out_valid), 64'd0);
      step();
    end
    rnd = t[23:16]; rnd_valid = 1'b1;
    @(negedge clk);
    chk("r39_acc", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; rnd_valid = 1'b0;
    repeat (4) step();
    chk("r39_count", 64'(ntx), 64'd1);

    // Reset with both stages occupied
    out_ready = 1'b0;
    t = rand64();
    send(t[7:0], t[15:8]);
    send(t[23:16], t[31:24]);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("r40_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("r40_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomised traffic, checked cycle-by-cycle by the model
    for (int k = 0; k < 400; k++) begin
      t = rand64();
      ina = t[7:0]; inb = t[15:8]; rnd = t[23:16];
      in_valid = t[24]; rnd_valid = t[25] | t[26];
      out_ready = (t[29:27] != 3'd0);
      step();
    end
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    // d=3 lanes: zero vs random randomness must recombine identically but mask differently
    rst1_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      t = rand64();
      ina1 = t[23:0]; inb1 = t[47:24];
      exp1 = comb1(ina1) & comb1(inb1);
      for (int pass = 0; pass < 2; pass++) begin
        t = rand64();
        rnd1 = (pass == 0) ? 48'h0 : t[47:0];
        in_valid1 = 1'b1; rnd_valid1 = 1'b1;
        @(negedge clk);
        chk("r41_acc", 64'(in_ready1), 64'd1);
        step();
        in_valid1 = 1'b0; rnd_valid1 = 1'b0;
        step();
        @(negedge clk);
        chk("r41_out_valid", 64'(out_valid1), 64'd1);
        if (pass == 0) o_z = out1;
        else o_r = out1;
        step();
      end
      chk("r41_zero_val", 64'(comb1(o_z)), 64'(exp1));
      chk("r41_rand_val", 64'(comb1(o_r)), 64'(exp1));
      chk("r41_shares_differ", 64'(o_r != o_z), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
